// File: rtl/sync_fifo_core_if.sv
// rtl/sync_fifo_core_if.sv - write/read handshake bundle for sync_fifo_core
interface sync_fifo_core_if #(
    parameter int WRITE_WIDTH = 8,
    parameter int READ_WIDTH  = 8
);
    logic [WRITE_WIDTH-1:0] wr_data_i;
    logic                   wr_en_i;
    logic [READ_WIDTH-1:0]  rd_data_o;
    logic                   rd_en_i;
    logic                   full_o;
    logic                   empty_o;

    modport master (
        output wr_data_i, wr_en_i, rd_en_i,
        input  rd_data_o, full_o, empty_o
    );

    modport slave (
        input  wr_data_i, wr_en_i, rd_en_i,
        output rd_data_o, full_o, empty_o
    );
endinterface

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - single-clock circular-buffer FIFO with integer write/read width conversion
module sync_fifo_core #(
    parameter int DLY         = 1,
    parameter int WRITE_WIDTH = 8,
    parameter int READ_WIDTH  = 8,
    parameter int FIFO_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    sync_fifo_core_if.slave fifo
);
    localparam int K  = WRITE_WIDTH / FIFO_WIDTH;
    localparam int M  = READ_WIDTH / FIFO_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (DLY < 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        K < 1 || K * FIFO_WIDTH != WRITE_WIDTH || (K & (K - 1)) != 0 || K > FIFO_DEPTH ||
        M < 1 || M * FIFO_WIDTH != READ_WIDTH  || (M & (M - 1)) != 0 || M > FIFO_DEPTH) begin : g_bad_params
        $error("sync_fifo_core: illegal parameter combination");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [READ_WIDTH-1:0] rd_data_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags depend only on registered count, so no input reaches an output combinationally.
    assign full   = count > CW'(FIFO_DEPTH - K);
    assign empty  = count < CW'(M);
    assign wr_acc = fifo.wr_en_i & ~full;
    assign rd_acc = fifo.rd_en_i & ~empty;

    assign fifo.full_o    = full;
    assign fifo.empty_o   = empty;
    assign fifo.rd_data_o = rd_data_q;

    // Storage is left out of reset so it can map onto a RAM; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < K; i++) begin
                mem[wr_ptr + AW'(i)] <= fifo.wr_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(K);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(M);
                for (int j = 0; j < M; j++) begin
                    rd_data_q[j*FIFO_WIDTH +: FIFO_WIDTH] <= mem[rd_ptr + AW'(j)];
                end
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(K);
                2'b01:   count <= count - CW'(M);
                2'b11:   count <= count + CW'(K) - CW'(M);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb/tb_sync_fifo_core.sv - bench for sync_fifo_core: directed vectors, random traffic vs queue model, width conversion
module tb_sync_fifo_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_core_if #(.WRITE_WIDTH(8),  .READ_WIDTH(8)) bus ();
    sync_fifo_core_if #(.WRITE_WIDTH(16), .READ_WIDTH(8)) bus_w ();

    sync_fifo_core dut (
        .clk_i (clk),
        .rst_i (rst),
        .fifo  (bus)
    );

    sync_fifo_core #(
        .WRITE_WIDTH (16),
        .READ_WIDTH  (8),
        .FIFO_WIDTH  (8),
        .FIFO_DEPTH  (4)
    ) dut_w (
        .clk_i (clk),
        .rst_i (rst),
        .fifo  (bus_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       ef;
        logic       ee;
        logic [7:0] er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic wr, logic [7:0] d, logic rd, logic ef, logic ee, logic [7:0] er);
        vec_t v;
        v.wr = wr; v.d = d; v.rd = rd; v.ef = ef; v.ee = ee; v.er = er;
        vecs.push_back(v);
    endfunction

    logic [7:0] q[$];
    logic [7:0] exp_rd;

    initial begin
        bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0; bus.wr_data_i = '0;
        bus_w.wr_en_i = 1'b0; bus_w.rd_en_i = 1'b0; bus_w.wr_data_i = '0;

        // Directed vector table: expectations follow from depth 32, K=M=1.
        for (int i = 0; i < 3; i++)  add(0, 8'h00, 1, 0, 1, 8'h00);
        for (int i = 0; i < 32; i++) add(1, 8'(i), 0, (i == 31), 0, 8'h00);
        add(1, 8'hAA, 0, 1, 0, 8'h00);
        for (int j = 0; j < 32; j++) add(0, 8'h00, 1, 0, (j == 31), 8'(j));
        for (int j = 0; j < 2; j++)  add(0, 8'h00, 1, 0, 1, 8'h1F);
        for (int i = 0; i < 32; i++) add(1, 8'(8'h40 + i), 0, (i == 31), 0, 8'h1F);
        add(1, 8'hCC, 1, 0, 0, 8'h40);
        for (int j = 0; j < 31; j++) add(0, 8'h00, 1, 0, (j == 30), 8'(8'h41 + j));
        add(1, 8'h77, 1, 0, 0, 8'h5F);
        add(0, 8'h00, 1, 0, 1, 8'h77);
        for (int i = 0; i < 10; i++) add(1, 8'(8'h80 + i), 0, 0, 0, 8'h77);
        add(1, 8'h90, 1, 0, 0, 8'h80);
        for (int j = 0; j < 10; j++) add(0, 8'h00, 1, 0, (j == 9), (j == 9) ? 8'h90 : 8'(8'h81 + j));

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset empty", bus.empty_o, 1);
        check("reset full", bus.full_o, 0);
        check("reset rd_data", bus.rd_data_o, 0);
        check("reset w empty", bus_w.empty_o, 1);
        check("reset w full", bus_w.full_o, 0);

        foreach (vecs[i]) begin
            bus.wr_en_i   = vecs[i].wr;
            bus.wr_data_i = vecs[i].d;
            bus.rd_en_i   = vecs[i].rd;
            tick();
            check($sformatf("vec%0d full", i), bus.full_o, vecs[i].ef);
            check($sformatf("vec%0d empty", i), bus.empty_o, vecs[i].ee);
            check($sformatf("vec%0d rd_data", i), bus.rd_data_o, vecs[i].er);
        end
        bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;

        // Reset in the middle of traffic discards stored data.
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_i = 1'b1; bus.wr_data_i = 8'(8'hE0 + i);
            tick();
        end
        bus.wr_en_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset empty", bus.empty_o, 1);
        check("midreset rd_data", bus.rd_data_o, 0);
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        check("midreset read ignored", bus.rd_data_o, 0);

        // Random traffic against a plain queue of stored words.
        exp_rd = 8'h00;
        for (int phase = 0; phase < 2; phase++) begin
            for (int cyc = 0; cyc < 200; cyc++) begin
                logic       wr, rd, m_full, m_empty;
                logic [7:0] d;
                wr = (phase == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
                rd = (phase == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
                d  = 8'($urandom);
                m_full  = q.size() > 31;
                m_empty = q.size() < 1;
                check($sformatf("rand p%0d c%0d full", phase, cyc), bus.full_o, m_full);
                check($sformatf("rand p%0d c%0d empty", phase, cyc), bus.empty_o, m_empty);
                bus.wr_en_i = wr; bus.wr_data_i = d; bus.rd_en_i = rd;
                tick();
                if (rd && !m_empty) exp_rd = q.pop_front();
                if (wr && !m_full) q.push_back(d);
                check($sformatf("rand p%0d c%0d rd_data", phase, cyc), bus.rd_data_o, exp_rd);
            end
        end
        bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
        check("rand final empty", bus.empty_o, q.size() < 1);
        check("rand final full", bus.full_o, q.size() > 31);

        // Width conversion: 16-bit writes, 8-bit reads, depth 4.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_w.wr_en_i = 1'b1; bus_w.wr_data_i = 16'hBBAA;
        tick();
        check("w wr1 full", bus_w.full_o, 0);
        check("w wr1 empty", bus_w.empty_o, 0);
        bus_w.wr_data_i = 16'hDDCC;
        tick();
        check("w wr2 full", bus_w.full_o, 1);
        bus_w.wr_data_i = 16'h1111;
        tick();
        check("w wr3 ignored full", bus_w.full_o, 1);
        bus_w.wr_en_i = 1'b0; bus_w.rd_en_i = 1'b1;
        tick();
        check("w rd1 data", bus_w.rd_data_o, 8'hAA);
        check("w rd1 full", bus_w.full_o, 1);
        tick();
        check("w rd2 data", bus_w.rd_data_o, 8'hBB);
        check("w rd2 full", bus_w.full_o, 0);
        tick();
        check("w rd3 data", bus_w.rd_data_o, 8'hCC);
        tick();
        check("w rd4 data", bus_w.rd_data_o, 8'hDD);
        check("w rd4 empty", bus_w.empty_o, 1);
        tick();
        check("w rd5 hold", bus_w.rd_data_o, 8'hDD);
        bus_w.rd_en_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
